// File: rtl/lcd_cmd_issuer.sv
// Command front-end for the image display controller: filters host opcodes,
// buffers legal ones in a circular FIFO and issues each once when the controller is idle.
//
// state  | meaning
// IDLE   | wait for a buffered opcode and busy low, then pop and strobe
// STROBE | cmd_valid high for exactly one cycle, busy ignored
// ACK    | wait for busy high as acceptance of the last strobe
// FINISH | terminal write issued; latch done into seq_done until reset
module lcd_cmd_issuer #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CW-1:0]              host_cmd,
    input  logic                       host_valid,
    output logic                       host_ready,
    input  logic                       busy,
    input  logic                       done,
    output logic [CW-1:0]              cmd,
    output logic                       cmd_valid,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_illegal,
    output logic                       seq_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LAST_LEGAL = CW'(11);
    localparam logic [CW-1:0] OP_WRITE = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        ACK    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t         state;
    logic [CW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           term_q;

    logic full, empty, handshake, legal, push, pop;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign host_ready = !full && !term_q;
    assign handshake  = host_valid && host_ready;
    assign legal      = (host_cmd <= LAST_LEGAL);
    assign push       = handshake && legal;
    assign pop        = (state == IDLE) && !empty && !busy;
    assign fifo_count = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            term_q      <= 1'b0;
            err_illegal <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            err_illegal <= handshake && !legal;
            if (push) begin
                mem[wr_ptr] <= host_cmd;
                wr_ptr      <= wr_ptr + 1'b1;
                if (host_cmd == OP_WRITE) term_q <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cmd       <= mem[rd_ptr];
                        cmd_valid <= 1'b1;
                        state     <= STROBE;
                    end
                end
                STROBE: begin
                    cmd_valid <= 1'b0;
                    state     <= (cmd == OP_WRITE) ? FINISH : ACK;
                end
                ACK: begin
                    if (busy) state <= IDLE;
                end
                FINISH: begin
                    if (done) seq_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lcd_cmd_issuer.md
# lcd_cmd_issuer

Command front-end that sits directly upstream of the image display controller and drives its `cmd`/`cmd_valid` inputs. It accepts opcodes from a host through a valid/ready port, filters illegal opcodes and buffers the rest in a small FIFO. It issues each buffered opcode to the controller exactly once, only when the controller reports `busy` low. After the terminal write command (0x0) it stops accepting input and tracks the controller's `done`.

## Interface
- `DEPTH`, 8, FIFO depth in entries; power of two, ≥2.
- `CW`, 4, opcode width; fixed to 4, matching the controller.

- `clk`  in  1  single clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- `host_cmd`  in  CW  opcode from host.
- `host_valid`  in  1  host offers `host_cmd` this cycle.
- `host_ready`  out  1  block accepts this cycle (combinational).
- `busy`  in  1  controller busy, combinational from the controller state.
- `done`  in  1  controller finished the write-back.
- `cmd`  out  CW  opcode to controller (registered).
- `cmd_valid`  out  1  one-cycle issue strobe (registered).
- `fifo_count`  out  log2(DEPTH)+1  entries currently buffered.
- `err_illegal`  out  1  one-cycle pulse when an opcode 0xC–0xF is handshaken and dropped.
- `seq_done`  out  1  sticky; the controller reported `done` after the write was issued.

## Operation
- Legal opcodes are 0x0–0xB. Opcode 0x0 (write) is terminal; all others are ordinary commands.
- `host_ready = !full && !term_q`, where `term_q` is set when a 0x0 is enqueued. `host_ready` depends only on state, never on `host_valid`.
- Handshake occurs when `host_valid && host_ready`:
  - Legal opcode: it is pushed into the FIFO.
  - Opcode ≥ 0xC: it is not pushed, and `err_illegal` = 1 in the next cycle.
- When the FIFO is full, no push occurs even if a pop happens in the same cycle. A push and a pop in the same non-full cycle leave `fifo_count` unchanged.
- FIFO is circular: read/write pointers wrap modulo DEPTH, and the count has an extra bit so full and empty are distinguishable.
- The issue FSM has four states: IDLE, STROBE, ACK and FINISH.
  - IDLE: when the FIFO is non-empty and `busy`==0, pop the head into `cmd`, set `cmd_valid`=1 and go to STROBE. Otherwise stay.
  - STROBE: this state lasts exactly one cycle, during which `cmd_valid` is held 1. At the end of the cycle, clear `cmd_valid`. Go to FINISH if the popped opcode was 0x0, otherwise go to ACK.
  - ACK: wait for `busy`==1, which acknowledges acceptance, then go to IDLE. IDLE then waits for `busy`==0 again before the next issue.
  - FINISH: when `done`==1, set `seq_done`=1. Remain in FINISH until reset; no further issues.
- Opcodes enqueued after a 0x0 are impossible because `term_q` blocks them. Entries ahead of the 0x0 drain in order.
- `cmd` holds the last issued opcode between strobes.

## Timing
- Reset asserted (`reset`=0) gives: `cmd`=0, `cmd_valid`=0, `fifo_count`=0, `err_illegal`=0, `seq_done`=0, FSM=IDLE, `term_q`=0. `host_ready` is then 1, since the FIFO is empty.
- Reset asserted mid-operation aborts any strobe immediately (`cmd_valid`→0) and discards FIFO contents.
- Push latency: an opcode handshaken at edge k is visible in `fifo_count` after edge k, and is eligible for issue in cycle k+1.
- Issue latency: head present and `busy`==0 sampled at edge n gives `cmd_valid`=1 during cycle n+1. The controller samples it at edge n+1.
- `busy` is ignored during STROBE. The controller raises `busy` during cycle n+2.
- Best-case throughput is one command per 3 cycles (IDLE→STROBE→ACK→IDLE with `busy` high for one cycle).
- After controller reset, `busy` stays high through the 64-cycle image fetch. No strobe may occur during this time; FIFO fills up to DEPTH.
- `seq_done` rises the cycle after `done` is first sampled high in FINISH.

## Test plan
- Startup hold: push 0x1, 0x4, 0x5 while `busy`=1 for 64 cycles, then drop `busy` → no `cmd_valid` before release. After release, three strobes carry 0x1, 0x4, 0x5 in order, each 1 cycle wide and ≥3 cycles apart.
- Full FIFO: hold `busy`=1 and push 10 legal opcodes with `host_valid` constant → `host_ready` drops after 8 accepts, `fifo_count`=8, and the 9th/10th are held by the host. Release `busy` → all 8 are issued in order.
- Illegal filter: push 0xC, 0x7, 0xF → `err_illegal` pulses twice, `fifo_count` peaks at 1, and only 0x7 is issued.
- Terminal write: push 0x9, 0x0, then attempt 0x2 → `host_ready`=0 after 0x0 is accepted and 0x2 is never accepted. Strobes carry 0x9 then 0x0. Assert `done` 70 cycles later → `seq_done`=1 and stays 1.
- Acknowledge wait: after a strobe, hold `busy`=0 for 5 extra cycles → no second strobe until `busy` has risen and fallen.
- Mid-run reset: pull `reset` low during STROBE with 3 entries queued → `cmd_valid`=0 immediately and `fifo_count`=0. After release, `host_ready`=1 and no stale opcodes are issued.
